// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DCO-side phase detector of the DPLL.
package dpll_pkg;

  localparam int unsigned FCW_WIDTH = 16;
  localparam int unsigned FRAC_W    = 8;
  localparam int unsigned PE_W      = 16;

  typedef logic signed [PE_W-1:0] phase_err_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } pd_state_e;

  // Accumulate a wide signed error into the 16-bit phase error, clamping at the rails.
  function automatic phase_err_t sat_add16(input phase_err_t acc, input logic signed [31:0] delta);
    logic signed [32:0] sum;
    sum = 33'(acc) + 33'(delta);
    if (sum > 33'sd32767) begin
      return 16'sh7fff;
    end else if (sum < -33'sd32768) begin
      return 16'sh8000;
    end
    return phase_err_t'(sum[15:0]);
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the DCO domain and flags its rising edges.
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic       meta;
  logic       sync;
  logic       sync_d;
  logic [1:0] sampled;
  logic       armed;

  // armed requires a genuine low sample after reset, so a reference that is
  // already high when reset releases is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      sync_d  <= 1'b0;
      sampled <= '0;
      armed   <= 1'b0;
    end else begin
      meta    <= async_in;
      sync    <= meta;
      sync_d  <= sync;
      sampled <= {sampled[0], 1'b1};
      armed   <= armed | (sampled[1] & ~sync);
    end
  end

  assign rise_c = sync & ~sync_d & armed;

endmodule

// File: rtl/dco_phase_detector.sv
// Counts DCO cycles per reference period, compares against the FCW and
// accumulates a saturated phase error with lock and reference-loss status.
module dco_phase_detector
  import dpll_pkg::*;
#(
  parameter int unsigned FCW_W       = FCW_WIDTH,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_TOL    = 64,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic             dco_clk,
  input  logic             dco_rst_n,
  input  logic             ref_clk,
  input  logic [FCW_W-1:0] fcw,
  output phase_err_t       phase_err,
  output logic             err_valid,
  output logic             locked,
  output logic             ref_lost
);

  localparam int unsigned MEAS_W = CNT_W + 1;
  localparam int unsigned ERR_W  = MEAS_W + FRAC_W;
  localparam int unsigned LC_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [ERR_W-1:0] TOL_P   = ERR_W'(LOCK_TOL);
  localparam logic signed [ERR_W-1:0] TOL_N   = -TOL_P;

  pd_state_e               state_q;
  pd_state_e               state_d;
  logic                    ref_edge;
  logic                    measure_c;
  logic                    lose_c;
  logic [CNT_W-1:0]        cnt;
  logic [MEAS_W-1:0]       meas_c;
  logic signed [ERR_W-1:0] ferr_c;
  logic signed [ERR_W-1:0] ferr_q;
  logic                    upd_q;
  logic                    in_tol_c;
  logic [LC_W-1:0]         lock_cnt;

  ref_edge_sync u_sync (
    .clk      (dco_clk),
    .rst_n    (dco_rst_n),
    .async_in (ref_clk),
    .rise_c   (ref_edge)
  );

  // meas_c is one wider than cnt so an edge on the saturated count yields 2^CNT_W.
  assign meas_c   = MEAS_W'(cnt) + MEAS_W'(1);
  assign ferr_c   = ERR_W'(fcw) - {meas_c, {FRAC_W{1'b0}}};
  assign in_tol_c = (ferr_q <= TOL_P) && (ferr_q >= TOL_N);

  always_ff @(posedge dco_clk) begin
    if (!dco_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An edge takes priority over counter saturation.
  always_comb begin
    state_d   = state_q;
    measure_c = 1'b0;
    lose_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_edge) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (ref_edge) begin
          measure_c = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE;
          lose_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dco_clk) begin
    if (!dco_rst_n) begin
      cnt       <= '0;
      ferr_q    <= '0;
      upd_q     <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      lock_cnt  <= '0;
      ref_lost  <= 1'b0;
    end else begin
      upd_q     <= measure_c;
      err_valid <= upd_q;
      if (measure_c) begin
        ferr_q <= ferr_c;
      end

      if (ref_edge) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (ref_edge) begin
        ref_lost <= 1'b0;
      end else if (lose_c) begin
        ref_lost <= 1'b1;
      end

      if (lose_c) begin
        phase_err <= '0;
        lock_cnt  <= '0;
        locked    <= 1'b0;
      end else if (upd_q) begin
        phase_err <= sat_add16(phase_err, 32'(ferr_q));
        if (in_tol_c) begin
          if (lock_cnt != LC_W'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LC_W'(1);
          end
          locked <= (lock_cnt >= LC_W'(LOCK_CYCLES - 1));
        end else begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dco_phase_detector.sv
// Self-checking bench for dco_phase_detector against a per-reference-edge behavioural model.
module tb_dco_phase_detector;
  import dpll_pkg::*;

  logic       dco_clk = 1'b0;
  logic       dco_rst_n;
  logic       ref_clk;
  logic [15:0] fcw;
  phase_err_t phase_err;
  logic       err_valid;
  logic       locked;
  logic       ref_lost;

  int checks = 0;
  int errors = 0;

  always #5 dco_clk = ~dco_clk;

  dco_phase_detector dut (
    .dco_clk   (dco_clk),
    .dco_rst_n (dco_rst_n),
    .ref_clk   (ref_clk),
    .fcw       (fcw),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .locked    (locked),
    .ref_lost  (ref_lost)
  );

  // Reference model: one update per reference rising edge.
  bit m_track;
  int m_acc;
  int m_lc;
  bit m_locked;
  bit m_lost;
  int m_prev;
  bit e_valid;

  // Observations over the most recent reference period.
  int o_nvalid;
  int o_pe_end;
  bit o_lock_end;
  bit o_lost_end;

  function automatic void model_reset();
    m_track  = 1'b0;
    m_acc    = 0;
    m_lc     = 0;
    m_locked = 1'b0;
    m_lost   = 1'b0;
    m_prev   = 0;
  endfunction

  // fcw_v is the word present at this edge; p is the period that follows it.
  function automatic void model_rise(input int fcw_v, input int p);
    int ferr;
    e_valid = m_track;
    m_lost  = 1'b0;
    if (m_track) begin
      ferr  = fcw_v - m_prev * 256;
      m_acc = m_acc + ferr;
      if (m_acc > 32767) m_acc = 32767;
      if (m_acc < -32768) m_acc = -32768;
      if (ferr <= 64 && ferr >= -64) m_lc = (m_lc < 4) ? m_lc + 1 : 4;
      else m_lc = 0;
      m_locked = (m_lc == 4);
    end
    m_track = 1'b1;
    m_prev  = p;
    if (p > 4096) begin
      m_track  = 1'b0;
      m_acc    = 0;
      m_lc     = 0;
      m_locked = 1'b0;
      m_lost   = 1'b1;
    end
  endfunction

  // One reference period of p DCO cycles starting with a rising edge; entered and left on a negedge.
  task automatic ref_period(input int fcw_v, input int p, input bit junk);
    model_rise(fcw_v, p);
    fcw      = 16'(fcw_v);
    ref_clk  = 1'b1;
    o_nvalid = 0;
    for (int i = 1; i <= p; i++) begin
      @(negedge dco_clk);
      if (i == p / 2) begin
        ref_clk = 1'b0;
        if (junk) fcw = 16'($urandom);
      end
      if (err_valid === 1'b1) o_nvalid++;
    end
    o_pe_end   = int'(phase_err);
    o_lock_end = locked;
    o_lost_end = ref_lost;
  endtask

  task automatic apply_reset();
    @(negedge dco_clk);
    dco_rst_n = 1'b0;
    ref_clk   = 1'b0;
    repeat (2) @(negedge dco_clk);
    dco_rst_n = 1'b1;
    repeat (10) @(negedge dco_clk);
    model_reset();
  endtask

  task automatic test_reset();
    dco_rst_n = 1'b0;
    ref_clk   = 1'b0;
    fcw       = '0;
    repeat (3) @(negedge dco_clk);
    checks++;
    if (phase_err !== 16'sd0 || err_valid !== 1'b0 || locked !== 1'b0 || ref_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset pe=%0d valid=%b lock=%b lost=%b required all 0", phase_err, err_valid, locked, ref_lost);
    end
    dco_rst_n = 1'b1;
    repeat (10) @(negedge dco_clk);
    model_reset();
  endtask

  task automatic test_steady();
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      ref_period(16'h1400, 20, 1'b1);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL steady[%0d] valid=%0d pe=%0d lock=%b lost=%b required valid=%0d pe=%0d lock=%b lost=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, o_lost_end, int'(e_valid), m_acc, m_locked, m_lost);
      end
    end
  endtask

  task automatic test_integer_mismatch();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      ref_period(16'h1400, 21, 1'b0);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL int_mismatch[%0d] valid=%0d pe=%0d lock=%b required valid=%0d pe=%0d lock=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, int'(e_valid), m_acc, m_locked);
      end
    end
  endtask

  task automatic test_fractional();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      ref_period(16'h1480, (k % 2 == 0) ? 20 : 21, 1'b1);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL fractional[%0d] valid=%0d pe=%0d lock=%b required valid=%0d pe=%0d lock=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, int'(e_valid), m_acc, m_locked);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 5) ref_period(16'h0100, 200, 1'b0);
      else ref_period(16'hff00, 8, 1'b0);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked) begin
        errors++;
        $display("FAIL saturation[%0d] valid=%0d pe=%0d lock=%b required valid=%0d pe=%0d lock=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, int'(e_valid), m_acc, m_locked);
      end
    end
  endtask

  task automatic test_ref_loss();
    int periods [13] = '{20, 20, 20, 20, 20, 20, 4096, 20, 20, 5000, 20, 20, 20};
    apply_reset();
    foreach (periods[k]) begin
      ref_period(16'h1400, periods[k], 1'b0);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL ref_loss[%0d] valid=%0d pe=%0d lock=%b lost=%b required valid=%0d pe=%0d lock=%b lost=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, o_lost_end, int'(e_valid), m_acc, m_locked, m_lost);
      end
    end
  endtask

  task automatic test_reset_mid_track();
    apply_reset();
    for (int k = 0; k < 6; k++) ref_period(16'h1400, 20, 1'b0);
    checks++;
    if (o_lock_end !== 1'b1) begin
      errors++;
      $display("FAIL premid_lock lock=%b required 1", o_lock_end);
    end
    dco_rst_n = 1'b0;
    @(negedge dco_clk);
    dco_rst_n = 1'b1;
    checks++;
    if (phase_err !== 16'sd0 || err_valid !== 1'b0 || locked !== 1'b0 || ref_lost !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset pe=%0d valid=%b lock=%b lost=%b required all 0", phase_err, err_valid, locked, ref_lost);
    end
    repeat (10) @(negedge dco_clk);
    model_reset();
    for (int k = 0; k < 7; k++) begin
      ref_period(16'h1400, 20, 1'b0);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL relock[%0d] valid=%0d pe=%0d lock=%b required valid=%0d pe=%0d lock=%b",
                 k, o_nvalid, o_pe_end, o_lock_end, int'(e_valid), m_acc, m_locked);
      end
    end
  endtask

  task automatic test_random();
    int p;
    int fv;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
      p = int'($urandom_range(8, 40));
      if ($urandom_range(0, 3) == 0) fv = int'($urandom_range(0, 65535));
      else fv = m_prev * 256 + int'($urandom_range(0, 200)) - 100;
      if (fv < 0) fv = 0;
      if (fv > 65535) fv = 65535;
      ref_period(fv, p, 1'b1);
      checks++;
      if (o_nvalid !== int'(e_valid) || o_pe_end !== m_acc || o_lock_end !== m_locked || o_lost_end !== m_lost) begin
        errors++;
        $display("FAIL random[%0d] fcw=%0d valid=%0d pe=%0d lock=%b required valid=%0d pe=%0d lock=%b",
                 k, fv, o_nvalid, o_pe_end, o_lock_end, int'(e_valid), m_acc, m_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_integer_mismatch();
    test_fractional();
    test_saturation();
    test_ref_loss();
    test_reset_mid_track();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
